// File: rtl/seven_seg_pkg.sv
// Shared definitions for the 7-segment display path.
// - GLYPHS: active-low {a,b,c,d,e,f,g} patterns for hex 0..F, indexed by value.
//   The LED decoder drives from this same table, so encoder and decoder cannot drift.
// - state_t: capture state machine encoding.
// - an_onehot_low / an_index / an_multi: anode vector helpers (active-low enables).
package seven_seg_pkg;

    localparam int unsigned CNT_W = 8;

    localparam logic [6:0] GLYPHS [16] = '{
        7'b0000001,  // 0
        7'b1001111,  // 1
        7'b0010010,  // 2
        7'b0000110,  // 3
        7'b1001100,  // 4
        7'b0100100,  // 5
        7'b0100000,  // 6
        7'b0001111,  // 7
        7'b0000000,  // 8
        7'b0000100,  // 9
        7'b0001000,  // A
        7'b1100000,  // b
        7'b0110001,  // C
        7'b1000010,  // d
        7'b0110000,  // E
        7'b0111000   // F
    };

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StHold
    } state_t;

    // True when exactly one anode is driven low.
    function automatic logic an_onehot_low(input logic [3:0] an);
        return ($countones(~an) == 1);
    endfunction

    // Index of the low anode; only meaningful when an_onehot_low(an) holds.
    function automatic logic [1:0] an_index(input logic [3:0] an);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!an[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

    // True when two or more anodes are low at once (bus contention).
    function automatic logic an_multi(input logic [3:0] an);
        return ($countones(~an) > 1);
    endfunction

endpackage

// File: rtl/seg_to_hex.sv
// Combinational inverse of the LED decoder.
// Ports:
//   seg   in  7  active-low {a,b,c,d,e,f,g}
//   hex   out 4  recovered hex value (0 when no match)
//   match out 1  pattern is one of the 16 hex glyphs; blank and others give 0
module seg_to_hex
    import seven_seg_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] hex,
    output logic       match
);

    always_comb begin
        hex   = 4'd0;
        match = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (seg == GLYPHS[i]) begin
                hex   = 4'(i);
                match = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seven_seg_capture.sv
// Receive-side monitor for the multiplexed four-digit 7-segment bus. Recovers, per
// digit, the hex value and decimal point being displayed once {an, seg} has been
// stable for STABLE_CYCLES consecutive samples.
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous active-low reset
//   an[3:0]      in   anode enables, active-low
//   seg[7:0]     in   {a,b,c,d,e,f,g,dp}, active-low
//   clear_err    in   synchronous clear of the sticky flags (a same-cycle set wins)
//   digits[15:0] out  recovered hex values, digit i at [4i+3:4i]
//   dp_out[3:0]  out  recovered decimal points, active-high
//   valid[3:0]   out  digit i holds a good capture
//   frame_done   out  one-cycle pulse when all four digits captured since last pulse
//   bad_pattern  out  sticky: a stable pattern matched no glyph
//   multi_anode  out  sticky: two or more anodes were low together
module seven_seg_capture
    import seven_seg_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  an,
    input  logic [7:0]  seg,
    input  logic        clear_err,
    output logic [15:0] digits,
    output logic [3:0]  dp_out,
    output logic [3:0]  valid,
    output logic        frame_done,
    output logic        bad_pattern,
    output logic        multi_anode
);

    localparam logic [CNT_W-1:0] STABLE_LIM = CNT_W'(STABLE_CYCLES);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [11:0]      prev_q;
    logic [15:0]      digits_q, digits_d;
    logic [3:0]       dp_q, dp_d;
    logic [3:0]       valid_q, valid_d;
    logic [3:0]       seen_q, seen_d;
    logic             frame_q, frame_d;
    logic             bad_q, bad_d;
    logic             multi_q, multi_d;

    logic             same;
    logic             one_hot;
    logic [1:0]       sel;
    logic             capture;
    logic [3:0]       hex;
    logic             match;
    logic [3:0]       seen_next;

    seg_to_hex u_seg_to_hex (
        .seg   (seg[7:1]),
        .hex   (hex),
        .match (match)
    );

    assign same    = ({an, seg} == prev_q);
    assign one_hot = an_onehot_low(an);
    assign sel     = an_index(an);

    // Stability tracking. The count saturates at STABLE_LIM while in HOLD, so a
    // long-held digit neither wraps nor recaptures.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        if (!one_hot) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d = StSettle;
                    cnt_d   = CNT_W'(1);
                end
                StSettle: begin
                    if (same) begin
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_d == STABLE_LIM) begin
                            capture = 1'b1;
                            state_d = StHold;
                        end
                    end else begin
                        cnt_d = CNT_W'(1);
                    end
                end
                StHold: begin
                    if (!same) begin
                        state_d = StSettle;
                        cnt_d   = CNT_W'(1);
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Capture datapath and frame tracking.
    always_comb begin
        digits_d  = digits_q;
        dp_d      = dp_q;
        valid_d   = valid_q;
        seen_d    = seen_q;
        frame_d   = 1'b0;
        seen_next = seen_q | (4'b0001 << sel);
        bad_d     = bad_q & ~clear_err;
        multi_d   = an_multi(an) | (multi_q & ~clear_err);
        if (capture) begin
            if (match) begin
                digits_d[{sel, 2'b00} +: 4] = hex;
                dp_d[sel]                   = ~seg[0];
                valid_d[sel]                = 1'b1;
                if (seen_next == 4'b1111) begin
                    frame_d = 1'b1;
                    seen_d  = 4'b0000;
                end else begin
                    seen_d = seen_next;
                end
            end else begin
                valid_d[sel] = 1'b0;
                bad_d        = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            prev_q   <= '1;
            digits_q <= '0;
            dp_q     <= '0;
            valid_q  <= '0;
            seen_q   <= '0;
            frame_q  <= 1'b0;
            bad_q    <= 1'b0;
            multi_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            prev_q   <= {an, seg};
            digits_q <= digits_d;
            dp_q     <= dp_d;
            valid_q  <= valid_d;
            seen_q   <= seen_d;
            frame_q  <= frame_d;
            bad_q    <= bad_d;
            multi_q  <= multi_d;
        end
    end

    assign digits      = digits_q;
    assign dp_out      = dp_q;
    assign valid       = valid_q;
    assign frame_done  = frame_q;
    assign bad_pattern = bad_q;
    assign multi_anode = multi_q;

endmodule
